// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush sequencer for a 5-stage pipeline. Drives the PC and
// inter-stage register enables plus bubble (flush) lines, resolving data
// memory wait, taken branches, load-use hazards and the halt-drain sequence.
// Keeps a saturating count of stall cycles.

module pipeline_hazard_ctrl #(
   parameter int CNT_W        = 16,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             ex_branch_taken,
   input  logic             halt_req,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_flush,
   output logic             halted,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [1:0] ST_RUN    = 2'b00;
   localparam logic [1:0] ST_DRAIN  = 2'b01;
   localparam logic [1:0] ST_HALTED = 2'b10;

   localparam int             DW         = $clog2(DRAIN_CYCLES + 1);
   localparam logic [DW-1:0]  DRAIN_INIT = DW'(DRAIN_CYCLES);
   localparam logic [DW-1:0]  DRAIN_ONE  = DW'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [DW-1:0]    drain_q, drain_d;
   logic [CNT_W-1:0] stall_q;
   logic             stall_inc;
   logic             freeze;
   logic             load_use;

   // Memory wait and the classic load-use interlock (r0 never creates a hazard).
   assign freeze   = mem_req & ~mem_ready;
   assign load_use = ex_mem_read & (ex_rt != 5'd0) &
                     ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));

   // Decide enables, flushes and next state from the current state and hazards.
   always_comb begin
      // NOTE: every output of this block gets a default here so no path can
      // leave one unassigned and infer a latch.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
      stall_inc   = 1'b0;
      state_d     = state_q;
      drain_d     = drain_q;

      if (reset) begin
         case (state_q)
            ST_RUN, ST_DRAIN: begin
               if (freeze) begin
                  // Only MEM/WB moves, and it takes a bubble while MEM waits.
                  memwb_en    = 1'b1;
                  memwb_flush = 1'b1;
                  stall_inc   = 1'b1;
               end else if (ex_branch_taken) begin
                  // Squash the two younger wrong-path instructions; a HALT
                  // among them is discarded, so any drain is abandoned.
                  pc_en      = 1'b1;
                  ifid_en    = 1'b1;
                  idex_en    = 1'b1;
                  exmem_en   = 1'b1;
                  memwb_en   = 1'b1;
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  state_d    = ST_RUN;
                  drain_d    = '0;
               end else if ((state_q == ST_RUN) && load_use) begin
                  // Hold PC and IF/ID one cycle, bubble into EX.
                  idex_en    = 1'b1;
                  idex_flush = 1'b1;
                  exmem_en   = 1'b1;
                  memwb_en   = 1'b1;
                  stall_inc  = 1'b1;
               end else if ((state_q == ST_DRAIN) || halt_req) begin
                  // Stop fetching and feed bubbles behind the HALT.
                  ifid_en    = 1'b1;
                  ifid_flush = 1'b1;
                  idex_en    = 1'b1;
                  exmem_en   = 1'b1;
                  memwb_en   = 1'b1;
                  if (state_q == ST_RUN) begin
                     state_d = ST_DRAIN;
                     drain_d = DRAIN_INIT;
                  end else begin
                     drain_d = drain_q - DRAIN_ONE;
                     if (drain_q == DRAIN_ONE) begin
                        state_d = ST_HALTED;
                     end
                  end
               end else begin
                  pc_en    = 1'b1;
                  ifid_en  = 1'b1;
                  idex_en  = 1'b1;
                  exmem_en = 1'b1;
                  memwb_en = 1'b1;
               end
            end
            ST_HALTED: begin
               // Frozen until reset; all enables and flushes stay low.
            end
            default: begin
               state_d = ST_RUN;
               drain_d = '0;
            end
         endcase
      end
   end

   // State and drain counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of its peers.
         state_q <= ST_RUN;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   // Saturating stall-cycle counter; sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
      end else if (stall_inc && (stall_q != CNT_MAX)) begin
         stall_q <= stall_q + CNT_ONE;
      end
   end

   assign state       = state_q;
   assign halted      = (state_q == ST_HALTED);
   assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: a wide-counter instance and a 2-bit
// counter instance share the same stimulus. Directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the sequencer.

module tb_pipeline_hazard_ctrl;

   localparam int DRAIN = 4;

   logic       clk;
   logic       reset;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken;
   logic       halt_req, mem_req, mem_ready;

   logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic        ifid_flush, idex_flush, memwb_flush, halted;
   logic [1:0]  state;
   logic [15:0] stall_count;

   logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
   logic        s_ifid_flush, s_idex_flush, s_memwb_flush, s_halted;
   logic [1:0]  s_state;
   logic [1:0]  s_stall_count;

   logic [7:0]  ctl, s_ctl;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model: halted flag, draining flag, advancing drain cycles
   // still owed, and the unbounded number of stall cycles seen.
   bit m_halted = 1'b0;
   bit m_drain  = 1'b0;
   int m_left   = 0;
   int m_stalls = 0;

   pipeline_hazard_ctrl #(.CNT_W(16), .DRAIN_CYCLES(DRAIN)) u_dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
      .halt_req(halt_req), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .memwb_flush(memwb_flush), .halted(halted), .state(state),
      .stall_count(stall_count)
   );

   pipeline_hazard_ctrl #(.CNT_W(2), .DRAIN_CYCLES(DRAIN)) u_sat (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
      .halt_req(halt_req), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
      .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
      .memwb_flush(s_memwb_flush), .halted(s_halted), .state(s_state),
      .stall_count(s_stall_count)
   );

   // Packed view: {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, memwb_fl}
   assign ctl   = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, memwb_flush};
   assign s_ctl = {s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en,
                   s_ifid_flush, s_idex_flush, s_memwb_flush};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Compare process: every falling edge, derive the outputs from the rules
   // and the model, compare both instances, then advance the model.
   always @(negedge clk) begin : compare
      logic [7:0] e_ctl;
      logic       fr, lu;
      int         sat16, sat2;
      if (!reset) begin
         m_halted = 1'b0;
         m_drain  = 1'b0;
         m_left   = 0;
         m_stalls = 0;
      end
      fr = mem_req & ~mem_ready;
      lu = ex_mem_read && (ex_rt != 0) &&
           ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
      if (!reset || m_halted)         e_ctl = 8'b00000_000;
      else if (fr)                    e_ctl = 8'b00001_001;
      else if (ex_branch_taken)       e_ctl = 8'b11111_110;
      else if (!m_drain && lu)        e_ctl = 8'b00111_010;
      else if (m_drain || halt_req)   e_ctl = 8'b01111_100;
      else                            e_ctl = 8'b11111_000;
      sat16 = (m_stalls > 65535) ? 65535 : m_stalls;
      sat2  = (m_stalls > 3) ? 3 : m_stalls;

      check("model_ctl", 32'(ctl), 32'(e_ctl));
      check("model_ctl_w2", 32'(s_ctl), 32'(e_ctl));
      check("model_state", 32'(state), m_halted ? 2 : (m_drain ? 1 : 0));
      check("model_halted", 32'(halted), 32'(m_halted));
      check("model_stall", 32'(stall_count), sat16);
      check("model_stall_w2", 32'(s_stall_count), sat2);

      if (reset && !m_halted) begin
         if (fr) m_stalls++;
         else if (ex_branch_taken) begin
            m_drain = 1'b0;
            m_left  = 0;
         end
         else if (!m_drain && lu) m_stalls++;
         else if (m_drain) begin
            m_left--;
            if (m_left == 0) begin
               m_drain  = 1'b0;
               m_halted = 1'b1;
            end
         end
         else if (halt_req) begin
            m_drain = 1'b1;
            m_left  = DRAIN;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs = 0; id_rt = 0; ex_rt = 0;
      id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
      ex_branch_taken = 0; halt_req = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      cyc();
      reset = 1'b1;
   endtask

   initial begin
      idle();
      reset = 1'b0;
      #3;
      check("rst_ctl", 32'(ctl), 0);
      check("rst_state", 32'(state), 0);
      check("rst_stall", 32'(stall_count), 0);
      check("rst_halted", 32'(halted), 0);
      cyc();
      reset = 1'b1;

      // Load-use: one bubble, one stall counted.
      ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_uses_rs = 1;
      #2;
      check("lu_ctl", 32'(ctl), 32'(8'b00111_010));
      check("lu_stall_before", 32'(stall_count), 0);
      cyc();
      ex_mem_read = 0;
      #2;
      check("lu_after_ctl", 32'(ctl), 32'(8'b11111_000));
      check("lu_stall", 32'(stall_count), 1);

      // No false hazard on r0 or on an unused rt.
      cyc(); idle();
      ex_mem_read = 1; ex_rt = 0; id_rs = 0; id_uses_rs = 1;
      #2;
      check("r0_ctl", 32'(ctl), 32'(8'b11111_000));
      cyc(); idle();
      ex_mem_read = 1; ex_rt = 5; id_rt = 5; id_uses_rt = 0;
      #2;
      check("unused_rt_ctl", 32'(ctl), 32'(8'b11111_000));
      check("nofalse_stall", 32'(stall_count), 1);

      // Memory wait: three frozen cycles, then the release cycle advances.
      cyc(); idle();
      mem_req = 1;
      for (int i = 0; i < 3; i++) begin
         #2;
         check("memwait_ctl", 32'(ctl), 32'(8'b00001_001));
         cyc();
      end
      mem_ready = 1;
      #2;
      check("memrel_ctl", 32'(ctl), 32'(8'b11111_000));
      check("memwait_stall", 32'(stall_count), 4);

      // Same with a taken branch held in the frozen EX stage.
      cyc(); idle();
      mem_req = 1; ex_branch_taken = 1;
      for (int i = 0; i < 3; i++) begin
         #2;
         check("membr_ctl", 32'(ctl), 32'(8'b00001_001));
         cyc();
      end
      mem_ready = 1;
      #2;
      check("membr_rel_ctl", 32'(ctl), 32'(8'b11111_110));
      check("membr_stall", 32'(stall_count), 7);

      // Branch beats halt.
      cyc(); idle();
      ex_branch_taken = 1; halt_req = 1;
      #2;
      check("brhalt_ctl", 32'(ctl), 32'(8'b11111_110));
      cyc(); idle();
      #2;
      check("brhalt_state", 32'(state), 0);
      check("brhalt_next_ctl", 32'(ctl), 32'(8'b11111_000));

      // Halt drain without interruption: halted from t+5.
      do_reset();
      halt_req = 1;
      #2;
      check("halt_t_ctl", 32'(ctl), 32'(8'b01111_100));
      cyc();
      halt_req = 0;
      for (int i = 1; i <= DRAIN; i++) begin
         #2;
         check("drain_ctl", 32'(ctl), 32'(8'b01111_100));
         check("drain_state", 32'(state), 1);
         cyc();
      end
      #2;
      check("halted_state", 32'(state), 2);
      check("halted_flag", 32'(halted), 1);
      check("halted_ctl", 32'(ctl), 0);
      ex_branch_taken = 1; mem_req = 1; ex_mem_read = 1; ex_rt = 3; id_rs = 3; id_uses_rs = 1;
      cyc();
      #2;
      check("halted_ignores_ctl", 32'(ctl), 0);
      check("halted_ignores_stall", 32'(stall_count), 0);

      // Halt with a 2-cycle freeze at t+2: halted from t+7.
      do_reset();
      halt_req = 1;
      cyc(); halt_req = 0;          // t+1
      cyc(); mem_req = 1;           // t+2
      #2;
      check("drainfrz_ctl", 32'(ctl), 32'(8'b00001_001));
      cyc();                        // t+3
      cyc(); mem_req = 0;           // t+4
      cyc();                        // t+5
      cyc();                        // t+6
      #2;
      check("drainfrz_t6_state", 32'(state), 1);
      cyc();                        // t+7
      #2;
      check("drainfrz_t7_state", 32'(state), 2);
      check("drainfrz_stall", 32'(stall_count), 2);

      // Branch at t+2 cancels the drain.
      do_reset();
      halt_req = 1;
      cyc(); halt_req = 0;          // t+1
      cyc(); ex_branch_taken = 1;   // t+2
      #2;
      check("drainbr_ctl", 32'(ctl), 32'(8'b11111_110));
      cyc(); ex_branch_taken = 0;   // t+3
      #2;
      check("drainbr_state", 32'(state), 0);
      check("drainbr_pc_en", 32'(pc_en), 1);

      // Saturation: six freeze cycles.
      do_reset();
      mem_req = 1;
      for (int i = 0; i < 6; i++) cyc();
      #2;
      check("sat_w2_stall", 32'(s_stall_count), 3);
      check("sat_w16_stall", 32'(stall_count), 6);
      mem_req = 0;

      // Asynchronous reset mid-drain.
      do_reset();
      ex_mem_read = 1; ex_rt = 7; id_rt = 7; id_uses_rt = 1;
      cyc(); idle();
      halt_req = 1;
      cyc(); halt_req = 0;
      cyc();
      #2;
      check("pre_rst_state", 32'(state), 1);
      check("pre_rst_stall", 32'(stall_count), 1);
      reset = 1'b0;
      #1;
      check("rst_drain_state", 32'(state), 0);
      check("rst_drain_stall", 32'(stall_count), 0);
      check("rst_drain_ctl", 32'(ctl), 0);
      cyc();
      reset = 1'b1;

      // Asynchronous reset mid-freeze.
      mem_req = 1;
      cyc(); cyc();
      #2;
      reset = 1'b0;
      #1;
      check("rst_frz_ctl", 32'(ctl), 0);
      check("rst_frz_stall", 32'(stall_count), 0);
      cyc(); idle();
      reset = 1'b1;
      #2;
      check("post_rst_ctl", 32'(ctl), 32'(8'b11111_000));

      // Randomized traffic; occasional resets recover from HALTED.
      for (int n = 0; n < 3000; n++) begin
         cyc();
         if (!reset) reset = 1'b1;
         else if ($urandom_range(0, 99) < 2) reset = 1'b0;
         id_rs           = 5'($urandom_range(0, 3));
         id_rt           = 5'($urandom_range(0, 3));
         ex_rt           = 5'($urandom_range(0, 3));
         id_uses_rs      = ($urandom_range(0, 1) == 1);
         id_uses_rt      = ($urandom_range(0, 1) == 1);
         ex_mem_read     = ($urandom_range(0, 99) < 35);
         ex_branch_taken = ($urandom_range(0, 99) < 10);
         halt_req        = ($urandom_range(0, 99) < 8);
         mem_req         = ($urandom_range(0, 99) < 30);
         mem_ready       = ($urandom_range(0, 1) == 1);
      end

      cyc(); idle();
      cyc();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It drives the enable input of each inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. It also drives per-stage flush lines; when a flush line is high, the datapath muxes zero (bubble) into that register's data input. It resolves data-memory wait, taken branches, load-use hazards and the halt-drain sequence, and keeps a saturating stall counter.

## Interface
- CNT_W, 16, width of stall counter
- DRAIN_CYCLES, 4, advancing cycles spent draining after a halt before freezing (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  5 each  source registers of instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  destination register of the load in EX
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- halt_req  in  1  ID instruction is HALT
- mem_req  in  1  MEM stage is accessing data memory
- mem_ready  in  1  data memory completes access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables
- ifid_flush, idex_flush, memwb_flush  out  1 each  load bubble into that register
- halted  out  1  pipeline frozen after halt
- state  out  2  RUN=00, DRAIN=01, HALTED=10
- stall_count  out  CNT_W  saturating stall-cycle count

## Operation
- Registered state: state, drain_cnt, stall_count. Enables and flushes are combinational from state and inputs.
- While reset=0:
  - state=RUN, drain_cnt=0, stall_count=0, halted=0.
  - All enables and flushes are forced to 0.
- Derived conditions:
  - freeze = mem_req & ~mem_ready.
  - load_use = ex_mem_read & (ex_rt≠0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- RUN, evaluated in priority order (first match wins):
  - freeze:
    - pc/ifid/idex/exmem en=0; memwb_en=1, memwb_flush=1.
    - stall_count++.
    - Stay in RUN. A pending branch is held in the frozen EX and is acted on after the freeze ends.
  - ex_branch_taken:
    - All en=1; ifid_flush=1, idex_flush=1.
    - Any halt_req this cycle is ignored (wrong path).
    - Stay in RUN.
  - load_use:
    - pc_en=0, ifid_en=0; idex_en=1, idex_flush=1; exmem_en=memwb_en=1.
    - stall_count++.
    - Stay in RUN. halt_req is deferred.
  - halt_req:
    - pc_en=0; ifid_en=1, ifid_flush=1; others en=1.
    - drain_cnt←DRAIN_CYCLES; go to DRAIN.
  - Otherwise: all en=1, all flush=0.
- DRAIN:
  - freeze:
    - Same outputs as in RUN.
    - drain_cnt holds; stall_count++.
  - ex_branch_taken (the HALT was wrong-path):
    - Same outputs as in RUN.
    - Go to RUN; drain_cnt←0.
  - Otherwise:
    - pc_en=0; ifid_en=1, ifid_flush=1; idex/exmem/memwb en=1.
    - drain_cnt--. When drain_cnt==1 this cycle, go to HALTED.
  - load_use and halt_req are not evaluated.
- HALTED:
  - All en=0, all flush=0, halted=1.
  - stall_count frozen; inputs ignored.
  - Exits only via reset.
- stall_count saturates at 2^CNT_W−1 and does not wrap.
- Flush lines may be high only where the matching enable is high.

## Timing
- Zero-cycle decision latency: enables and flushes respond in the same cycle as the inputs.
- State, drain_cnt and stall_count update on the rising clk edge.
- Load-use inserts exactly one bubble per hazard occurrence.
- A freeze lasts exactly as long as mem_req & ~mem_ready.
  - The cycle in which mem_ready=1 is an advancing cycle and is not counted as a stall.
- halt_req at cycle t:
  - With no freezes, DRAIN covers cycles t+1..t+DRAIN_CYCLES; halted=1 from cycle t+DRAIN_CYCLES+1.
  - Each freeze cycle during DRAIN delays HALTED by one cycle.
- Asserting reset mid-DRAIN or mid-freeze returns immediately (asynchronously) to RUN with counters cleared.
  - The first advancing cycle is the first rising edge after reset deasserts.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5, id_uses_rs=1 for one cycle → pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; stall_count 0→1; next cycle (ex_mem_read=0) all en=1.
- No false hazard: ex_rt=0, id_rs=0, id_uses_rs=1, ex_mem_read=1 → all en=1, stall_count stays 0. Also: id_rt=5 match with id_uses_rt=0 → no stall.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 → 3 cycles with pc/ifid/idex/exmem en=0 and memwb_flush=1, then one cycle with all en=1; stall_count=3. Repeat with ex_branch_taken=1 throughout: flushes appear only on the release cycle.
- Branch beats halt: ex_branch_taken=1 and halt_req=1 in the same cycle → ifid_flush=idex_flush=1, pc_en=1, state stays 00.
- Halt drain: halt_req pulse at t → pc_en=0 and ifid_flush=1 for cycles t..t+4; state=10 and halted=1 from t+5 with all en=0. A 2-cycle freeze inserted at t+2 → halted from t+7. A branch at t+2 → state 00 at t+3 with pc_en=1.
- Saturation and reset: CNT_W=2 with a freeze held 6 cycles → stall_count sticks at 3. Asserting reset low mid-DRAIN → state=00, stall_count=0, all outputs 0 immediately.
